ms_lane_arbiter: RTL and testbench
==================================

Name: ms_lane_arbiter

Overview:
Shares one registered modular add/sub unit (mod Q = 3329) among N_REQ requester lanes.
- Arbitration is round-robin; one operation is accepted per cycle.
- The result is returned one cycle later through a single output register with valid/ready backpressure, tagged with the lane ID.
- Sits between the multi-lane butterfly/RPMA lane controllers and the single shared modular subtract datapath.

Parameters:
N_REQ, 4, number of requester lanes (2..8)
DW, 12, coefficient width
Q, 3329, modulus; operands and results lie in [0, Q-1]

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-lane request valid
req_ready  output  N_REQ  per-lane accept (one-hot or zero)
req_op  input  N_REQ  per-lane op: 0 = a-b mod Q, 1 = a+b mod Q
req_a  input  N_REQ*DW  lane i operand a at [i*DW +: DW]
req_b  input  N_REQ*DW  lane i operand b at [i*DW +: DW]
rsp_valid  output  1  result register valid
rsp_ready  input  1  downstream accepts result
rsp_data  output  DW  modular result
rsp_id  output  $clog2(N_REQ)  lane index of the result

Behaviour:
- Reset (synchronous, active-high):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation drops any held result; no response is produced for it.
- Accept condition: can_issue = !rsp_valid || rsp_ready.
- Grant logic:
  - When can_issue is high, the grant goes to the first lane with req_valid set, scanning rr_ptr, rr_ptr+1, … (mod N_REQ).
  - req_ready = grant, one-hot, combinational from req_valid, rr_ptr and can_issue.
  - Requesters must not make req_valid depend on req_ready.
  - If can_issue=0 or no lane is valid, req_ready=0.
- Handshake: transfer occurs when req_valid[i] && req_ready[i]. A requester holds valid, op, a and b stable until transfer.
- rr_ptr update: on a transfer from lane g, rr_ptr <= (g+1) mod N_REQ. Otherwise rr_ptr is unchanged.
- Latency: a transfer in cycle t sets rsp_valid=1 with rsp_data and rsp_id at edge t+1.
- Output register update rules:
  - On a transfer: load result and lane ID.
  - Else if rsp_ready: rsp_valid <= 0.
  - Else: hold all outputs stable.
  - A simultaneous consume and new transfer in the same cycle gives back-to-back results; throughput is 1 per cycle.
- Arithmetic, using (DW+1)-bit intermediates:
  - sub: d = a - b; if borrow, result = d + Q, else d.
  - add: s = a + b; if s >= Q, result = s - Q, else s.
- Operands >= Q are out of contract; the result is whatever the formulas above produce.
- No state machine beyond the output valid flag and rr_ptr. Fairness: a continuously valid lane is granted within N_REQ accepted transfers.

Optional Feature:
Macro MS_RANGE_CHK_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0), registered alongside rsp_data.
  - rsp_err=1 when the accepted a >= Q or b >= Q; the result is still computed per the formulas.
- Undefined: rsp_err port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package ms_pkg holds:
  - constants KYBER_Q=12'd3329 and COEF_W=12;
  - op encoding constants OP_SUB=1'b0, OP_ADD=1'b1.
- Sub-module ms_addsub_core: purely combinational mod-Q add/sub (inputs a, b, op; output s).
- Arbiter, rr_ptr and output register stay in ms_lane_arbiter.

Test Plan:
- Single lane 0: sub a=5, b=10 -> one cycle later rsp_valid=1, rsp_data=3324, rsp_id=0. Then sub a=10, b=5 -> 5.
- Lane 2: add a=3000, b=500 -> rsp_data=171. Add a=3328, b=1 -> 0. Add a=0, b=0 -> 0.
- All 4 lanes valid continuously, rsp_ready=1, from reset -> grants 0,1,2,3,0,1, one per cycle; rsp_id follows one cycle later.
- rsp_ready=0 for 3 cycles while a result is held -> rsp_data/rsp_id stable and req_ready=0 throughout; on rsp_ready=1 the next grant is issued in the same cycle and no result is lost or duplicated.
- Assert rst for one cycle while rsp_valid=1 and lanes 1 and 3 are requesting -> rsp_valid=0 the next cycle, and rr_ptr=0 so lane 1 is granted first after reset.
- With MS_RANGE_CHK_EN: add a=3329, b=0 -> rsp_err=1, rsp_data=0. Sub a=100, b=4095 -> rsp_err=1. In-range ops -> rsp_err=0.

Source files
------------

// File: rtl/ms_pkg.sv
// Shared constants for the mod-Q lane arbiter and its add/sub core.
package ms_pkg;
  localparam int          COEF_W  = 12;
  localparam logic [11:0] KYBER_Q = 12'd3329;
  localparam logic        OP_SUB  = 1'b0;
  localparam logic        OP_ADD  = 1'b1;
endpackage

// File: rtl/ms_addsub_core.sv
// Combinational modular add/sub: s = (a +/- b) mod Q using one-bit-wider intermediates.
module ms_addsub_core
  import ms_pkg::*;
#(
  parameter int DW = COEF_W,
  parameter int Q  = 3329
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          op,
  output logic [DW-1:0] s
);
  localparam logic [DW:0] QX = (DW+1)'(Q);

  logic [DW:0] diff;
  logic [DW:0] sum;
  logic [DW:0] diff_fix;
  logic [DW:0] sum_fix;

  assign diff     = {1'b0, a} - {1'b0, b};
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff_fix = diff + QX;
  assign sum_fix  = sum - QX;

  // diff[DW] is the borrow out of the subtraction.
  always_comb begin
    s = '0;
    if (op == OP_ADD) s = (sum >= QX) ? sum_fix[DW-1:0] : sum[DW-1:0];
    else              s = diff[DW] ? diff_fix[DW-1:0] : diff[DW-1:0];
  end
endmodule

// File: rtl/ms_lane_arbiter.sv
// Round-robin arbiter sharing one registered mod-Q add/sub unit among N_REQ lanes.
// Optional range-check flag output rsp_err is enabled with MS_RANGE_CHK_EN.
module ms_lane_arbiter
  import ms_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = COEF_W,
  parameter int Q     = 3329
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_op,
  input  logic [N_REQ*DW-1:0]      req_a,
  input  logic [N_REQ*DW-1:0]      req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DW-1:0]            rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id
`ifdef MS_RANGE_CHK_EN
  ,
  output logic                     rsp_err
`endif
);
  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    gidx;
  logic             found;
  logic             can_issue;
  logic [N_REQ-1:0] grant;
  logic             xfer;
  logic [DW-1:0]    a_sel;
  logic [DW-1:0]    b_sel;
  logic             op_sel;
  logic [DW-1:0]    result;
  logic [IW-1:0]    next_ptr;

  // Handshake: a lane transfers when req_valid[i] && req_ready[i]; the lane holds
  // op/a/b stable until then, and must not make req_valid depend on req_ready.
  assign can_issue = !rsp_valid || rsp_ready;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        found = 1'b1;
        gidx  = IW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found && can_issue && !rst) grant[gidx] = 1'b1;
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign a_sel     = req_a[gidx*DW +: DW];
  assign b_sel     = req_b[gidx*DW +: DW];
  assign op_sel    = req_op[gidx];
  assign next_ptr  = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;

  ms_addsub_core #(.DW(DW), .Q(Q)) u_core (
    .a  (a_sel),
    .b  (b_sel),
    .op (op_sel),
    .s  (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_data  <= result;
      rsp_id    <= gidx;
      rr_ptr    <= next_ptr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef MS_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)       rsp_err <= 1'b0;
    else if (xfer) rsp_err <= (a_sel >= DW'(Q)) || (b_sel >= DW'(Q));
  end
`endif
endmodule

// File: tb/tb_ms_lane_arbiter.sv
// Directed bench for ms_lane_arbiter: hand-computed vectors checked with immediate assertions.
// Range-flag checks are included when MS_RANGE_CHK_EN is defined.
module tb_ms_lane_arbiter;
  localparam int N  = 4;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_op;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_id;
`ifdef MS_RANGE_CHK_EN
  logic            rsp_err;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] rr_exp [N];

  ms_lane_arbiter #(.N_REQ(N), .DW(DW), .Q(3329)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef MS_RANGE_CHK_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_op[i]          = op;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [DW-1:0] data, input logic [1:0] id);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"},  32'(rsp_data),  32'(data));
    check({tag, "_id"},    32'(rsp_id),    32'(id));
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    step(); step();
    // Reset state; req_ready must stay low while rst is high even with requests.
    req_valid = 4'b1111;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data",  32'(rsp_data),  32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
`ifdef MS_RANGE_CHK_EN
    check("rst_err",   32'(rsp_err),   32'd0);
`endif
    req_valid = '0;
    rst = 1'b0;
    step();

    // Single lane 0: sub with borrow, then plain sub.
    set_lane(0, 1'b0, 12'd5, 12'd10); req_valid = 4'b0001; #1;
    check("l0_ready_a", 32'(req_ready), 32'b0001);
    step(); check_rsp("l0_sub_5_10", 12'd3324, 2'd0);
    set_lane(0, 1'b0, 12'd10, 12'd5); #1;
    check("l0_ready_b", 32'(req_ready), 32'b0001);
    step(); check_rsp("l0_sub_10_5", 12'd5, 2'd0);
    req_valid = '0;
    step(); check("l0_drain", 32'(rsp_valid), 32'd0);

    // Lane 2 additions around the modulus.
    set_lane(2, 1'b1, 12'd3000, 12'd500); req_valid = 4'b0100; #1;
    check("l2_ready", 32'(req_ready), 32'b0100);
    step(); check_rsp("l2_add_3000_500", 12'd171, 2'd2);
    set_lane(2, 1'b1, 12'd3328, 12'd1);
    step(); check_rsp("l2_add_3328_1", 12'd0, 2'd2);
    set_lane(2, 1'b1, 12'd0, 12'd0);
    step(); check_rsp("l2_add_0_0", 12'd0, 2'd2);
    req_valid = '0;
    step(); check("l2_drain", 32'(rsp_valid), 32'd0);

    // Round robin from reset with all lanes valid: lane i adds (i*100+1) + i.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, 1'b1, 12'(i*100 + 1), 12'(i));
    rr_exp[0] = 12'd1; rr_exp[1] = 12'd102; rr_exp[2] = 12'd203; rr_exp[3] = 12'd304;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % N)));
      step();
      check_rsp($sformatf("rr_rsp%0d", k), rr_exp[k % N], 2'(k % N));
    end

    // Backpressure: lane 1 result held for 3 cycles, no grants meanwhile.
    rsp_ready = 1'b0; #1;
    check("bp_ready0", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_rsp($sformatf("bp_hold%0d", k), 12'd102, 2'd1);
      check($sformatf("bp_ready_hold%0d", k), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1; #1;
    check("bp_release_grant", 32'(req_ready), 32'b0100);
    step(); check_rsp("bp_next2", 12'd203, 2'd2);
    step(); check_rsp("bp_next3", 12'd304, 2'd3);

    // Reset mid-operation with a held result and lanes 1,3 requesting.
    req_valid = 4'b1010; rsp_ready = 1'b0; rst = 1'b1; #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_id",    32'(rsp_id),    32'd0);
    rst = 1'b0; rsp_ready = 1'b1; #1;
    check("post_rst_grant", 32'(req_ready), 32'b0010);
    step(); check_rsp("post_rst_l1", 12'd102, 2'd1);
    check("post_rst_grant3", 32'(req_ready), 32'b1000);
    step(); check_rsp("post_rst_l3", 12'd304, 2'd3);
    req_valid = '0;
    step(); check("post_rst_drain", 32'(rsp_valid), 32'd0);

`ifdef MS_RANGE_CHK_EN
    // Range flag: out-of-range operands still go through the formulas.
    set_lane(0, 1'b1, 12'd3329, 12'd0); req_valid = 4'b0001;
    step(); check_rsp("rc_add_3329_0", 12'd0, 2'd0);
    check("rc_err_a", 32'(rsp_err), 32'd1);
    set_lane(0, 1'b0, 12'd100, 12'd4095);
    step(); check_rsp("rc_sub_100_4095", 12'd3430, 2'd0);
    check("rc_err_b", 32'(rsp_err), 32'd1);
    set_lane(0, 1'b1, 12'd1, 12'd2);
    step(); check_rsp("rc_add_1_2", 12'd3, 2'd0);
    check("rc_err_ok", 32'(rsp_err), 32'd0);
    req_valid = '0;
    step();
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
